// File: rtl/morphle_pkg.sv
// rtl/morphle_pkg.sv - dual-rail token values, red-cell state type and lane encode/decode helpers
package morphle_pkg;

    localparam logic [1:0] V_EMPTY = 2'b00;
    localparam logic [1:0] V_0     = 2'b01;
    localparam logic [1:0] V_1     = 2'b10;
    localparam logic [1:0] V_ERR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RZ
    } state_t;

    function automatic logic [1:0] encode(input logic b);
        return b ? V_1 : V_0;
    endfunction

    // Empty and illegal lanes both read back as 0; illegal is flagged separately.
    function automatic logic decode(input logic [1:0] v);
        return v == V_1;
    endfunction

    function automatic logic is_err(input logic [1:0] v);
        return v == V_ERR;
    endfunction

endpackage

// File: rtl/morphle_dr_sync.sv
// rtl/morphle_dr_sync.sv - multi-flop synchronizer for the up-going dual-rail wires
module morphle_dr_sync
    import morphle_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         primed
);

    logic [W-1:0]      ff [STAGES];
    logic [STAGES-1:0] fill;

    // fill marks when every stage holds a post-reset sample, so q is a true view of d
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                ff[i] <= '0;
            end
            fill <= '0;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
            fill <= {fill[STAGES-2:0], 1'b1};
        end
    end

    assign q      = ff[STAGES-1];
    assign primed = fill[STAGES-1];

endmodule

// File: rtl/morphle_redcell.sv
// rtl/morphle_redcell.sv - clocked red cell: host word <-> four-phase dual-rail tokens
// Optional watchdog enabled by REDCELL_TIMEOUT_EN.
module morphle_redcell
    import morphle_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [LANES-1:0]   tx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic [LANES-1:0]   rx_data,
    output logic               rx_err,
    output logic               net_empty,
    output logic [2*LANES-1:0] net_out,
    input  logic [2*LANES-1:0] net_in
);

    state_t             state;
    logic [2*LANES-1:0] sb;
    logic               sync_primed;
    logic               all_full;
    logic               all_empty;
    logic               dec_err;
    logic [LANES-1:0]   dec_data;
    logic [2*LANES-1:0] tx_enc;
    logic               tx_fire;
    logic               rx_fire;
    logic               tmo_hit;
    logic               leave_state;

    morphle_dr_sync #(
        .STAGES (SYNC_STAGES),
        .W      (2*LANES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (net_in),
        .q       (sb),
        .primed  (sync_primed)
    );

    always_comb begin
        all_full  = 1'b1;
        all_empty = 1'b1;
        dec_err   = 1'b0;
        dec_data  = '0;
        tx_enc    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (sb[2*i +: 2] == V_EMPTY) begin
                all_full = 1'b0;
            end else begin
                all_empty = 1'b0;
            end
            dec_data[i]      = decode(sb[2*i +: 2]);
            dec_err          = dec_err | is_err(sb[2*i +: 2]);
            tx_enc[2*i +: 2] = encode(tx_data[i]);
        end
    end

    // sync_primed keeps the port closed until the synchronizer reflects the real network after reset
    assign tx_ready = (state == IDLE) & en & ~net_empty & sync_primed & all_empty
                    & (~rx_valid | rx_ready);
    assign tx_fire  = tx_valid & tx_ready;
    assign rx_fire  = rx_valid & rx_ready;

    always_comb begin
        leave_state = 1'b0;
        case (state)
            IDLE:    leave_state = tx_fire;
            DRIVE:   leave_state = all_full | tmo_hit;
            RZ:      leave_state = all_empty | tmo_hit;
            default: leave_state = 1'b1;
        endcase
    end

`ifdef REDCELL_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = &tmo_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || leave_state) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            net_out   <= '0;
            net_empty <= 1'b1;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            rx_err    <= 1'b0;
        end else begin
            if (rx_fire) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    net_empty <= ~en;
                    if (tx_fire) begin
                        net_out <= tx_enc;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    // a watchdog capture reports the missing lanes as 0 and flags the word
                    if (leave_state) begin
                        rx_data  <= dec_data;
                        rx_err   <= dec_err | ~all_full;
                        rx_valid <= 1'b1;
                        net_out  <= '0;
                        state    <= RZ;
                    end
                end
                RZ: begin
                    if (leave_state) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    net_out <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
